// File: rtl/img_filter_pkg.sv
// Shared types and constants for the 3x3 streaming image filter.
package img_filter_pkg;

    typedef enum logic [1:0] {
        FILT_BYPASS = 2'd0,
        FILT_GAUSS  = 2'd1,
        FILT_EDGE   = 2'd2,
        FILT_SHARP  = 2'd3
    } filt_mode_e;

    localparam int PIX_MAX  = 255;
    localparam int SUM_W    = 12;
    localparam int FILT_LAT = 2;

    function automatic logic [7:0] clamp_pix(input logic signed [SUM_W-1:0] v);
        logic [7:0] r;
        if (v[SUM_W-1]) begin
            r = 8'd0;
        end else if (v > $signed(SUM_W'(PIX_MAX))) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/img_filter3x3_line_buffer.sv
// Single-port line buffer: synchronous read-before-write plus a same-cycle view
// of the addressed word so a second buffer can be cascaded in lockstep.
module line_buffer #(
    parameter int DEPTH = 225,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH-1:0]         old_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    assign old_data = mem_r[addr];

    // Old word is captured on the same edge the new word is written.
    always_ff @(posedge clk) begin
        if (en) begin
            rd_data     <= mem_r[addr];
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/img_filter3x3.sv
// Streaming 3x3 greyscale filter (bypass/gaussian/edge/sharpen), one output per input, 2-cycle latency.
// Build option FILTER_THRESH_EN adds i_thresh and binarises the non-bypass result.
module img_filter3x3
    import img_filter_pkg::*;
#(
    parameter int IMG_W  = 225,
    parameter int IMG_H  = 225,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
`ifdef FILTER_THRESH_EN
    input  logic [DATA_W-1:0] i_thresh,
`endif
    output logic              o_valid,
    output logic              o_sof,
    output logic [DATA_W-1:0] o_data
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0]     x_r, cur_x_s, nxt_x_s;
    logic [YW-1:0]     y_r, cur_y_s, nxt_y_s;
    logic              border_s;
    filt_mode_e        mode_r, s0_mode_r;
    logic              s0_valid_r, s0_sof_r, s0_border_r;
    logic [DATA_W-1:0] s0_data_r;
    logic [DATA_W-1:0] a_rd_s, b_rd_s, a_old_s;
    logic [DATA_W-1:0] col_s [3];
    logic [DATA_W-1:0] win_r [3][2];
`ifdef FILTER_THRESH_EN
    logic [DATA_W-1:0] thr_r, s0_thr_r;
`endif

    logic [SUM_W-1:0]        ctr_u_s, orth_u_s, diag_u_s, gauss_u_s;
    logic signed [SUM_W-1:0] edge_s, edge_abs_s, sharp_s;
    logic [DATA_W-1:0]       pre_s, res_s;

    // Coordinate of the pixel being accepted and of the one after it.
    always_comb begin
        cur_x_s = i_sof ? {XW{1'b0}} : x_r;
        cur_y_s = i_sof ? {YW{1'b0}} : y_r;
        nxt_x_s = x_r;
        nxt_y_s = y_r;
        if (i_valid) begin
            if (cur_x_s == XW'(IMG_W - 1)) begin
                nxt_x_s = {XW{1'b0}};
                nxt_y_s = (cur_y_s == YW'(IMG_H - 1)) ? {YW{1'b0}} : cur_y_s + YW'(1);
            end else begin
                nxt_x_s = cur_x_s + XW'(1);
                nxt_y_s = cur_y_s;
            end
        end else begin
            nxt_x_s = x_r;
            nxt_y_s = y_r;
        end
        border_s = (cur_x_s < XW'(2)) || (cur_y_s < YW'(2));
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_a (
        .clk      (clk),
        .en       (i_valid),
        .addr     (cur_x_s),
        .wr_data  (i_data),
        .rd_data  (a_rd_s),
        .old_data (a_old_s)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_b (
        .clk      (clk),
        .en       (i_valid),
        .addr     (cur_x_s),
        .wr_data  (a_old_s),
        .rd_data  (b_rd_s),
        .old_data ()
    );

    // Stage 0: counters, frame-stable mode, and per-pixel side info.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            mode_r      <= FILT_BYPASS;
            s0_mode_r   <= FILT_BYPASS;
            s0_valid_r  <= 1'b0;
            s0_sof_r    <= 1'b0;
            s0_border_r <= 1'b0;
            s0_data_r   <= {DATA_W{1'b0}};
`ifdef FILTER_THRESH_EN
            thr_r       <= {DATA_W{1'b0}};
            s0_thr_r    <= {DATA_W{1'b0}};
`endif
        end else begin
            x_r        <= nxt_x_s;
            y_r        <= nxt_y_s;
            s0_valid_r <= i_valid;
            if (i_valid) begin
                s0_sof_r    <= i_sof;
                s0_data_r   <= i_data;
                s0_border_r <= border_s;
                s0_mode_r   <= i_sof ? filt_mode_e'(i_mode) : mode_r;
`ifdef FILTER_THRESH_EN
                s0_thr_r    <= i_sof ? i_thresh : thr_r;
`endif
            end
            if (i_valid && i_sof) begin
                mode_r <= filt_mode_e'(i_mode);
`ifdef FILTER_THRESH_EN
                thr_r  <= i_thresh;
`endif
            end
        end
    end

    // Right column of the window is consumed directly so the result lands one edge later.
    assign col_s[0] = b_rd_s;
    assign col_s[1] = a_rd_s;
    assign col_s[2] = s0_data_r;

    // Kernel arithmetic; gaussian stays unsigned because its sum reaches 4080.
    always_comb begin
        ctr_u_s    = SUM_W'(win_r[1][1]);
        orth_u_s   = SUM_W'(win_r[0][1]) + SUM_W'(win_r[2][1]) + SUM_W'(win_r[1][0]) + SUM_W'(col_s[1]);
        diag_u_s   = SUM_W'(win_r[0][0]) + SUM_W'(col_s[0]) + SUM_W'(win_r[2][0]) + SUM_W'(col_s[2]);
        gauss_u_s  = (ctr_u_s << 3'd2) + (orth_u_s << 3'd1) + diag_u_s;
        edge_s     = $signed(ctr_u_s << 3'd3) - $signed(orth_u_s + diag_u_s);
        edge_abs_s = edge_s[SUM_W-1] ? -edge_s : edge_s;
        sharp_s    = $signed((ctr_u_s << 3'd2) + ctr_u_s) - $signed(orth_u_s);
        if (s0_border_r || (s0_mode_r == FILT_BYPASS)) begin
            pre_s = s0_data_r;
        end else begin
            case (s0_mode_r)
                FILT_GAUSS: pre_s = DATA_W'(gauss_u_s >> 3'd4);
                FILT_EDGE:  pre_s = DATA_W'(clamp_pix(edge_abs_s));
                FILT_SHARP: pre_s = DATA_W'(clamp_pix(sharp_s));
                default:    pre_s = s0_data_r;
            endcase
        end
`ifdef FILTER_THRESH_EN
        if (s0_mode_r != FILT_BYPASS) begin
            res_s = (pre_s >= s0_thr_r) ? DATA_W'(PIX_MAX) : {DATA_W{1'b0}};
        end else begin
            res_s = pre_s;
        end
`else
        res_s = pre_s;
`endif
    end

    // Output register and window shift, both advancing only on valid pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_data  <= {DATA_W{1'b0}};
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= {DATA_W{1'b0}};
                win_r[r][1] <= {DATA_W{1'b0}};
            end
        end else begin
            o_valid <= s0_valid_r;
            o_sof   <= s0_valid_r & s0_sof_r;
            if (s0_valid_r) begin
                o_data <= res_s;
                for (int r = 0; r < 3; r++) begin
                    win_r[r][0] <= win_r[r][1];
                    win_r[r][1] <= col_s[r];
                end
            end
        end
    end

endmodule
